// File: rtl/inst_decode_stage_if.sv
// ---------------------------------------------------------------------------
// inst_decode_stage_if
// Handshake bundle between fetch, the decode stage and execute.
//   in_valid/in_ready/in_inst/in_pc   : upstream instruction handshake
//   out_valid/out_ready               : downstream bundle handshake
//   out_pc/out_rs1/out_rs2/out_rd     : decoded operands and address
//   out_imm/out_aluop/out_src2_imm    : ALU controls and immediate
//   out_wen/out_illegal/out_ebreak    : writeback enable and class flags
// Modports: slave = the decode stage, master = the surrounding pipeline.
// ---------------------------------------------------------------------------
interface inst_decode_stage_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_inst;
   logic [XLEN-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [4:0]      out_rd;
   logic [XLEN-1:0] out_imm;
   logic [3:0]      out_aluop;
   logic            out_src2_imm;
   logic            out_wen;
   logic            out_illegal;
   logic            out_ebreak;

   modport slave (
      input  in_valid, in_inst, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
             out_imm, out_aluop, out_src2_imm, out_wen, out_illegal, out_ebreak
   );

   modport master (
      output in_valid, in_inst, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
             out_imm, out_aluop, out_src2_imm, out_wen, out_illegal, out_ebreak
   );
endinterface

// File: rtl/inst_decode_stage.sv
// ---------------------------------------------------------------------------
// inst_decode_stage
// One-register RV32I/RV64I subset decoder (OP-IMM, LUI, AUIPC, optional OP,
// EBREAK). Accepted instructions appear decoded one cycle later; the bundle
// is held while downstream stalls. Accepting EBREAK halts intake until reset.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : decode handshake bundle (slave side)
//   halted : sticky, set the cycle after an EBREAK is accepted
// ---------------------------------------------------------------------------
module inst_decode_stage #(
   parameter int XLEN      = 32,
   parameter int SUPPORT_R = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   inst_decode_stage_if.slave        bus,
   output logic                      halted
);
   localparam logic [6:0]  OPC_OPIMM = 7'b0010011;
   localparam logic [6:0]  OPC_LUI   = 7'b0110111;
   localparam logic [6:0]  OPC_AUIPC = 7'b0010111;
   localparam logic [6:0]  OPC_OP    = 7'b0110011;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB = 4'd1,  ALU_SLL = 4'd2,
                          ALU_SLT = 4'd3,  ALU_SLTU = 4'd4, ALU_XOR = 4'd5,
                          ALU_SRL = 4'd6,  ALU_SRA = 4'd7,  ALU_OR  = 4'd8,
                          ALU_AND = 4'd9,  ALU_LUI = 4'd10, ALU_AUIPC = 4'd11;

   function automatic logic signed [XLEN-1:0] sext_i(input logic [11:0] f);
      logic signed [11:0] s;
      s = signed'(f);
      return XLEN'(s);
   endfunction

   function automatic logic signed [XLEN-1:0] sext_u(input logic [19:0] f);
      logic signed [31:0] s;
      s = signed'({f, 12'b0});
      return XLEN'(s);
   endfunction

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [5:0] shamt;
   logic       shamt_ok;

   logic                   legal_p0, ebreak_p0;
   logic [4:0]             rs1_p0, rs2_p0, rd_p0;
   logic signed [XLEN-1:0] imm_p0;
   logic [3:0]             aluop_p0;
   logic                   src2_imm_p0;

   logic                   vld_p1, legal_p1, ebreak_p1, wen_p1, src2_imm_p1;
   logic [XLEN-1:0]        pc_p1;
   logic [4:0]             rs1_p1, rs2_p1, rd_p1;
   logic signed [XLEN-1:0] imm_p1;
   logic [3:0]             aluop_p1;
   logic                   accept;

   assign opcode = bus.in_inst[6:0];
   assign funct3 = bus.in_inst[14:12];
   assign funct7 = bus.in_inst[31:25];
   // RV32 shifts only have a 5-bit shamt, so inst[25] must be clear there.
   assign shamt    = (XLEN == 64) ? bus.in_inst[25:20] : {1'b0, bus.in_inst[24:20]};
   assign shamt_ok = (XLEN == 64) || !bus.in_inst[25];

   // Stage p0: combinational decode of the offered instruction
   always_comb begin
      legal_p0    = 1'b0;
      ebreak_p0   = 1'b0;
      rs1_p0      = bus.in_inst[19:15];
      rs2_p0      = 5'd0;
      rd_p0       = bus.in_inst[11:7];
      imm_p0      = '0;
      aluop_p0    = ALU_ADD;
      src2_imm_p0 = 1'b1;
      if (bus.in_inst == INST_EBREAK) begin
         ebreak_p0 = 1'b1;
      end else begin
         unique case (opcode)
            OPC_OPIMM: begin
               imm_p0   = sext_i(bus.in_inst[31:20]);
               legal_p0 = 1'b1;
               unique case (funct3)
                  3'b000: aluop_p0 = ALU_ADD;
                  3'b010: aluop_p0 = ALU_SLT;
                  3'b011: aluop_p0 = ALU_SLTU;
                  3'b100: aluop_p0 = ALU_XOR;
                  3'b110: aluop_p0 = ALU_OR;
                  3'b111: aluop_p0 = ALU_AND;
                  3'b001: begin
                     aluop_p0 = ALU_SLL;
                     imm_p0   = $signed(XLEN'(shamt));
                     legal_p0 = shamt_ok && (bus.in_inst[31:26] == 6'b000000);
                  end
                  default: begin
                     imm_p0 = $signed(XLEN'(shamt));
                     if (bus.in_inst[31:26] == 6'b010000) aluop_p0 = ALU_SRA;
                     else                                 aluop_p0 = ALU_SRL;
                     legal_p0 = shamt_ok && ((bus.in_inst[31:26] == 6'b000000) ||
                                             (bus.in_inst[31:26] == 6'b010000));
                  end
               endcase
            end
            OPC_LUI, OPC_AUIPC: begin
               legal_p0 = 1'b1;
               rs1_p0   = 5'd0;
               imm_p0   = sext_u(bus.in_inst[31:12]);
               aluop_p0 = (opcode == OPC_LUI) ? ALU_LUI : ALU_AUIPC;
            end
            OPC_OP: begin
               src2_imm_p0 = 1'b0;
               rs2_p0      = bus.in_inst[24:20];
               if (SUPPORT_R != 0) begin
                  if (funct7 == 7'b0000000) begin
                     legal_p0 = 1'b1;
                     unique case (funct3)
                        3'b000:  aluop_p0 = ALU_ADD;
                        3'b001:  aluop_p0 = ALU_SLL;
                        3'b010:  aluop_p0 = ALU_SLT;
                        3'b011:  aluop_p0 = ALU_SLTU;
                        3'b100:  aluop_p0 = ALU_XOR;
                        3'b101:  aluop_p0 = ALU_SRL;
                        3'b110:  aluop_p0 = ALU_OR;
                        default: aluop_p0 = ALU_AND;
                     endcase
                  end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                     legal_p0 = 1'b1;
                     aluop_p0 = ALU_SUB;
                  end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                     legal_p0 = 1'b1;
                     aluop_p0 = ALU_SRA;
                  end
               end
            end
            default: legal_p0 = 1'b0;
         endcase
      end
      // Illegal and EBREAK bundles carry no operand information.
      if (!legal_p0) begin
         rs1_p0      = 5'd0;
         rs2_p0      = 5'd0;
         rd_p0       = 5'd0;
         imm_p0      = '0;
         aluop_p0    = ALU_ADD;
         src2_imm_p0 = 1'b0;
      end
   end

   assign bus.in_ready = !halted && (!vld_p1 || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;

   // Stage p1: output register, held while downstream stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1      <= 1'b0;
         halted      <= 1'b0;
         pc_p1       <= '0;
         rs1_p1      <= 5'd0;
         rs2_p1      <= 5'd0;
         rd_p1       <= 5'd0;
         imm_p1      <= '0;
         aluop_p1    <= 4'd0;
         src2_imm_p1 <= 1'b0;
         wen_p1      <= 1'b0;
         legal_p1    <= 1'b0;
         ebreak_p1   <= 1'b0;
      end else begin
         if (accept) begin
            vld_p1      <= 1'b1;
            pc_p1       <= bus.in_pc;
            rs1_p1      <= rs1_p0;
            rs2_p1      <= rs2_p0;
            rd_p1       <= rd_p0;
            imm_p1      <= imm_p0;
            aluop_p1    <= aluop_p0;
            src2_imm_p1 <= src2_imm_p0;
            wen_p1      <= legal_p0 && (rd_p0 != 5'd0);
            legal_p1    <= legal_p0;
            ebreak_p1   <= ebreak_p0;
            if (ebreak_p0) halted <= 1'b1;
         end else if (bus.out_ready) begin
            vld_p1 <= 1'b0;
         end
      end
   end

   assign bus.out_valid    = vld_p1;
   assign bus.out_pc       = pc_p1;
   assign bus.out_rs1      = rs1_p1;
   assign bus.out_rs2      = rs2_p1;
   assign bus.out_rd       = rd_p1;
   assign bus.out_imm      = imm_p1;
   assign bus.out_aluop    = aluop_p1;
   assign bus.out_src2_imm = src2_imm_p1;
   assign bus.out_wen      = wen_p1;
   assign bus.out_illegal  = !legal_p1 && !ebreak_p1 && vld_p1;
   assign bus.out_ebreak   = ebreak_p1;
endmodule
